// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester / transmitter bundle shared by the UART TX arbiter.
//               master : drives requests and the transmitter completion pulse
//               slave  : the arbiter (accepts bytes, drives the transmitter)
// Signals     : req_valid[N_REQ]   byte-valid per requester
//               req_data[8*N_REQ]  requester i's byte in bits [8i+7:8i]
//               req_ready[N_REQ]   one-hot accept from the arbiter
//               tx_data[8]         latched byte to the transmitter
//               tx_start           one-cycle start pulse to the transmitter
//               tx_done            one-cycle completion pulse from transmitter
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_done;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data, tx_start
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one UART transmitter between
//               several byte producers. Grants one requester, latches its
//               byte, pulses tx_start and waits for tx_done (or a watchdog
//               expiry) before granting again.
// Ports       : clk          system clock
//               rst          asynchronous, active-low reset
//               bus          uart_tx_arbiter_if.slave (requests + transmitter)
//               grant_id[2]  index of the last granted requester
//               busy         high in every state except IDLE
//               err_timeout  sticky watchdog flag, cleared only by reset
// Notes       : The rotating search relies on 2-bit index wrap-around, so
//               N_REQ must stay at 4.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 200_000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               err_timeout
);

  localparam int IDW   = 2;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_ISSUE     = 2'd1;
  localparam logic [1:0] c_WAIT_DONE = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_grant;
  logic [7:0]       r_tx_data;
  logic             r_err;
  logic [CNT_W-1:0] r_wdog;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_idx;
  logic             w_in_idle;

  // Rotating priority search: start one past the last grant and take the
  // first valid index. The 2-bit sum wraps modulo 4 by itself; k = N_REQ
  // lands back on r_last so it is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    w_idx    = r_last;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = r_last + IDW'(k);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_in_idle = (r_state == c_IDLE);

  // Gated by rst so ready reads zero for the whole reset window, even if a
  // requester is already holding valid.
  assign bus.req_ready = (rst && w_in_idle && w_found) ?
                         (N_REQ'(1) << w_winner) : '0;

  // Decoded straight from the state register: no extra pulse register, so an
  // asynchronous reset in ISSUE drops tx_start immediately.
  assign bus.tx_start  = (r_state == c_ISSUE);
  assign bus.tx_data   = r_tx_data;
  assign busy          = !w_in_idle;
  assign grant_id      = r_grant;
  assign err_timeout   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      r_last    <= IDW'(N_REQ - 1);
      r_grant   <= IDW'(N_REQ - 1);
      r_tx_data <= 8'h00;
      r_err     <= 1'b0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_tx_data <= bus.req_data[{w_winner, 3'b000} +: 8];
            r_grant   <= w_winner;
            r_last    <= w_winner;
            r_state   <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_wdog  <= '0;
          r_state <= c_WAIT_DONE;
        end
        c_WAIT_DONE: begin
          // tx_done has priority over a watchdog expiry in the same cycle.
          if (bus.tx_done) begin
            r_state <= c_IDLE;
          end else if (r_wdog == c_CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= c_IDLE;
          end else begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Stimulus loads
//               batches of bytes per requester; a round-robin reference model
//               predicts the grant order into a scoreboard queue, and a
//               monitor checks every cycle's outputs against it together
//               with a cycle-based transmitter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       err_timeout;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  // requester byte stores: head advanced by the monitor on accept,
  // tail advanced by the stimulus on load
  logic [7:0] mem [N][64];
  int         head [N] = '{default: 0};
  int         tail [N] = '{default: 0};
  logic [N-1:0] ghost = '0;
  logic       stray  = 1'b0;

  // transmitter model: 0 random delay, 1 never done, 2 done at expiry cycle,
  // 3 fixed delay, 4 random mix of all
  int         tx_mode  = 0;
  int         tx_delay = 5;
  int         done_at  = -1;

  int         model_last = N - 1;
  logic [7:0] b_bytes [N][8];
  int         b_cnt [N];

  // monitor state
  int         busy_from = -1;
  int         busy_to   = -1;
  int         err_at    = -1;
  bit         pend      = 1'b0;
  int         pend_id;
  logic [7:0] pend_byte;
  logic [7:0] last_byte = 8'h00;
  int         last_id   = 3;
  int         m_c, m_d, m_mode, m_r;
  bit         m_eb, m_ee;
  logic [N-1:0] m_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // requester and transmitter drivers
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = mem[i][head[i] % 64];
      end else begin
        bus.req_valid[i]       = ghost[i];
        bus.req_data[8*i +: 8] = 8'hEE;
      end
    end
    bus.tx_done = (cyc == done_at) || stray;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      busy_from = -1; busy_to = -1; err_at = -1; pend = 1'b0; done_at = -1;
      last_byte = 8'h00; last_id = 3;
    end else begin
      m_c = cyc;
      if (pend) begin
        chk("tx_start_issue", 32'(bus.tx_start), 32'd1);
        chk("tx_data_issue", 32'(bus.tx_data), 32'(pend_byte));
        chk("grant_id_issue", 32'(grant_id), 32'(pend_id));
        last_byte = pend_byte;
        last_id   = pend_id;
        m_mode = tx_mode;
        m_d    = (tx_mode == 3) ? tx_delay : int'($urandom_range(1, TMO - 1));
        if (m_mode == 4) begin
          m_r    = int'($urandom_range(0, 9));
          m_mode = (m_r == 0) ? 1 : (m_r == 1) ? 2 : 0;
        end
        if (m_mode == 1) begin
          done_at = -1;
          busy_to = m_c + TMO;
          if (err_at < 0) err_at = m_c + TMO + 1;
        end else if (m_mode == 2) begin
          done_at = m_c + TMO;
          busy_to = m_c + TMO;
        end else begin
          done_at = m_c + m_d;
          busy_to = m_c + m_d;
        end
        pend = 1'b0;
      end else begin
        chk("tx_start_quiet", 32'(bus.tx_start), 32'd0);
        chk("tx_data_hold", 32'(bus.tx_data), 32'(last_byte));
        chk("grant_id_hold", 32'(grant_id), 32'(last_id));
      end
      m_eb = (busy_from >= 0) && (m_c >= busy_from) && (m_c <= busy_to);
      chk("busy", 32'(busy), 32'(m_eb));
      m_ee = (err_at >= 0) && (m_c >= err_at);
      chk("err_timeout", 32'(err_timeout), 32'(m_ee));
      if (m_eb || bus.req_valid == '0 || sb.size() == 0) m_rdy = '0;
      else m_rdy = N'(1) << sb[0].id;
      chk("req_ready", 32'(bus.req_ready), 32'(m_rdy));
      if (m_rdy != '0 && bus.req_ready == m_rdy) begin
        pend      = 1'b1;
        pend_id   = sb[0].id;
        pend_byte = sb[0].data;
        head[pend_id]++;
        void'(sb.pop_front());
        busy_from = m_c + 1;
        busy_to   = 32'h7fff_ffff;
      end
    end
  end

  // Reference model: every loaded requester holds valid until its bytes are
  // used up, so the grant order is plain rotation over non-empty queues.
  task automatic load_batch();
    int   used [N];
    int   idx;
    bit   any;
    exp_t e;
    for (int i = 0; i < N; i++) used[i] = 0;
    do begin
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (model_last + k) % N;
        if (used[idx] < b_cnt[idx]) begin
          e.id   = idx;
          e.data = b_bytes[idx][used[idx]];
          sb.push_back(e);
          used[idx]++;
          model_last = idx;
          any = 1'b1;
          break;
        end
      end
    end while (any);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < b_cnt[i]; j++) mem[i][(tail[i] + j) % 64] = b_bytes[i][j];
      tail[i] += b_cnt[i];
    end
  endtask

  task automatic clear_batch();
    for (int i = 0; i < N; i++) b_cnt[i] = 0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !pend && busy == 1'b0)) begin
      @(negedge clk);
      k++;
      if (k > budget) begin
        n_tests++; n_fail++;
        $display("FAIL drain: %0d grants still outstanding after %0d cycles", sb.size(), budget);
        sb.delete();
        for (int i = 0; i < N; i++) tail[i] = head[i];
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_grant_id", 32'(grant_id), 32'd3);
  endtask

  initial begin
    clear_batch();
    repeat (3) @(negedge clk);
    #1 chk_reset_values();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // all four requesting: order 0,1,2,3
    tx_mode = 0;
    for (int i = 0; i < N; i++) begin b_cnt[i] = 1; b_bytes[i][0] = 8'hA0 + 8'(i); end
    load_batch(); drain(20 + 4 * (TMO + 4));

    // single request
    clear_batch(); b_cnt[2] = 1; b_bytes[2][0] = 8'h11;
    load_batch(); drain(20 + TMO + 4);

    // fairness: req0 and req2 each with three bytes
    clear_batch(); b_cnt[0] = 3; b_cnt[2] = 3;
    for (int j = 0; j < 3; j++) begin
      b_bytes[0][j] = 8'h50 + 8'(j); b_bytes[2][j] = 8'h70 + 8'(j);
    end
    load_batch(); drain(20 + 6 * (TMO + 4));

    // randomized batches with a mix of normal, missing and racing tx_done
    tx_mode = 4;
    for (int r = 0; r < 12; r++) begin
      int tot = 0;
      for (int i = 0; i < N; i++) begin
        b_cnt[i] = int'($urandom_range(0, 3));
        tot += b_cnt[i];
        for (int j = 0; j < 8; j++) b_bytes[i][j] = 8'($urandom);
      end
      load_batch(); drain(20 + tot * (TMO + 4));
    end

    // watchdog, then the next request must still be served
    tx_mode = 1;
    clear_batch(); b_cnt[1] = 1; b_bytes[1][0] = 8'hC1;
    load_batch(); drain(20 + TMO + 4);
    tx_mode = 0;
    clear_batch(); b_cnt[3] = 1; b_bytes[3][0] = 8'hC3;
    load_batch(); drain(20 + TMO + 4);

    // tx_done racing the watchdog expiry
    tx_mode = 2;
    clear_batch(); b_cnt[0] = 1; b_bytes[0][0] = 8'hD0;
    load_batch(); drain(20 + TMO + 4);

    // a requester that withdraws before being granted is never served
    tx_mode = 3; tx_delay = 20;
    clear_batch(); b_cnt[3] = 1; b_bytes[3][0] = 8'hE3;
    load_batch();
    repeat (4) @(negedge clk);
    ghost[1] = 1'b1;
    repeat (6) @(negedge clk);
    ghost[1] = 1'b0;
    drain(20 + TMO + 4);
    tx_mode = 0;
    clear_batch(); b_cnt[0] = 1; b_cnt[1] = 1; b_bytes[0][0] = 8'hF0; b_bytes[1][0] = 8'hF1;
    load_batch(); drain(20 + 2 * (TMO + 4));

    // stray tx_done in IDLE has no effect
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    clear_batch(); b_cnt[2] = 1; b_bytes[2][0] = 8'h22;
    load_batch(); drain(20 + TMO + 4);

    // asynchronous reset in the middle of WAIT_DONE
    tx_mode = 1;
    clear_batch(); b_cnt[1] = 1; b_bytes[1][0] = 8'h77;
    load_batch();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset_values();
    sb.delete();
    model_last = N - 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tx_mode = 0;
    clear_batch(); b_cnt[2] = 1; b_cnt[3] = 1; b_cnt[0] = 1;
    b_bytes[0][0] = 8'h30; b_bytes[2][0] = 8'h32; b_bytes[3][0] = 8'h33;
    load_batch(); drain(20 + 3 * (TMO + 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit expired");
  end

endmodule
`default_nettype wire
